// File: rtl/axi_lite_to_axi_tracked.sv
// AXI4-Lite to AXI4 bridge: single-beat bursts with a fixed ID, bounded outstanding
// reads/writes, and absorption plus sticky flagging of unexpected or malformed responses.
package axi_lite_to_axi_tracked_pkg;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned IdW   = 4;
    localparam int unsigned UserW = 1;

    typedef struct packed { logic [AddrW-1:0] addr; logic [2:0] prot; } lite_ax_t;
    typedef struct packed { logic [DataW-1:0] data; logic [DataW/8-1:0] strb; } lite_w_t;
    typedef struct packed { logic [1:0] resp; } lite_b_t;
    typedef struct packed { logic [DataW-1:0] data; logic [1:0] resp; } lite_r_t;

    typedef struct packed {
        lite_ax_t aw; logic aw_valid;
        lite_w_t  w;  logic w_valid;
        logic     b_ready;
        lite_ax_t ar; logic ar_valid;
        logic     r_ready;
    } lite_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        lite_b_t b; logic b_valid;
        logic    ar_ready;
        lite_r_t r; logic r_valid;
    } lite_resp_t;

    typedef struct packed {
        logic [IdW-1:0] id; logic [AddrW-1:0] addr; logic [7:0] len; logic [2:0] size;
        logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos;
        logic [3:0] region; logic [5:0] atop; logic [UserW-1:0] user;
    } full_aw_t;

    typedef struct packed {
        logic [IdW-1:0] id; logic [AddrW-1:0] addr; logic [7:0] len; logic [2:0] size;
        logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos;
        logic [3:0] region; logic [UserW-1:0] user;
    } full_ar_t;

    typedef struct packed {
        logic [DataW-1:0] data; logic [DataW/8-1:0] strb; logic last; logic [UserW-1:0] user;
    } full_w_t;

    typedef struct packed { logic [IdW-1:0] id; logic [1:0] resp; logic [UserW-1:0] user; } full_b_t;

    typedef struct packed {
        logic [IdW-1:0] id; logic [DataW-1:0] data; logic [1:0] resp; logic last;
        logic [UserW-1:0] user;
    } full_r_t;

    typedef struct packed {
        full_aw_t aw; logic aw_valid;
        full_w_t  w;  logic w_valid;
        logic     b_ready;
        full_ar_t ar; logic ar_valid;
        logic     r_ready;
    } full_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        full_b_t b; logic b_valid;
        full_r_t r; logic r_valid;
    } full_resp_t;
endpackage

module axi_lite_to_axi_tracked #(
    parameter int unsigned             AxiAddrWidth = axi_lite_to_axi_tracked_pkg::AddrW,
    parameter int unsigned             AxiDataWidth = axi_lite_to_axi_tracked_pkg::DataW,
    parameter int unsigned             AxiIdWidth   = axi_lite_to_axi_tracked_pkg::IdW,
    parameter int unsigned             AxiUserWidth = axi_lite_to_axi_tracked_pkg::UserW,
    parameter logic [AxiIdWidth-1:0]   AxiId        = '0,
    parameter logic [3:0]              AxiCache     = 4'b0011,
    parameter int unsigned             MaxWriteTxns = 4,
    parameter int unsigned             MaxReadTxns  = 4,
    parameter type lite_req_t  = axi_lite_to_axi_tracked_pkg::lite_req_t,
    parameter type lite_resp_t = axi_lite_to_axi_tracked_pkg::lite_resp_t,
    parameter type full_req_t  = axi_lite_to_axi_tracked_pkg::full_req_t,
    parameter type full_resp_t = axi_lite_to_axi_tracked_pkg::full_resp_t
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  lite_req_t  slv_req_i,
    output lite_resp_t slv_resp_o,
    output full_req_t  mst_req_o,
    input  full_resp_t mst_resp_i,
    input  logic       err_clr_i,
    output logic       busy_o,
    output logic [3:0] err_o
);
    localparam int unsigned WCntW = $clog2(MaxWriteTxns + 1);
    localparam int unsigned RCntW = $clog2(MaxReadTxns + 1);
    localparam logic [WCntW-1:0] WMax = WCntW'(MaxWriteTxns);
    localparam logic [RCntW-1:0] RMax = RCntW'(MaxReadTxns);
    localparam logic [2:0] Size = 3'($clog2(AxiDataWidth / 8));

    logic [WCntW-1:0] r_wr_cnt;
    logic [RCntW-1:0] r_rd_cnt;
    logic [3:0]       r_err;

    logic w_wr_full, w_wr_empty, w_rd_full, w_rd_empty;
    logic w_aw_hs, w_ar_hs;
    logic w_b_ready, w_b_acc, w_b_fwd_hs;
    logic w_r_fwd, w_r_ready, w_r_acc, w_r_fwd_hs;
    logic [3:0] w_err_set;
    logic w_unused_user;

    assign w_wr_full  = (r_wr_cnt == WMax);
    assign w_wr_empty = (r_wr_cnt == '0);
    assign w_rd_full  = (r_rd_cnt == RMax);
    assign w_rd_empty = (r_rd_cnt == '0);

    assign w_aw_hs = slv_req_i.aw_valid & mst_resp_i.aw_ready & ~w_wr_full;
    assign w_ar_hs = slv_req_i.ar_valid & mst_resp_i.ar_ready & ~w_rd_full;

    // With nothing outstanding, responses are sunk here instead of reaching the lite side.
    assign w_b_ready  = w_wr_empty | slv_req_i.b_ready;
    assign w_b_acc    = mst_resp_i.b_valid & w_b_ready;
    assign w_b_fwd_hs = w_b_acc & ~w_wr_empty;

    // Non-last R beats are swallowed too; only a last beat completes a lite read.
    assign w_r_fwd    = ~w_rd_empty & mst_resp_i.r.last;
    assign w_r_ready  = ~w_r_fwd | slv_req_i.r_ready;
    assign w_r_acc    = mst_resp_i.r_valid & w_r_ready;
    assign w_r_fwd_hs = w_r_acc & w_r_fwd;

    assign w_err_set[0] = w_b_acc & w_wr_empty;
    assign w_err_set[1] = w_r_acc & w_rd_empty;
    assign w_err_set[2] = (w_b_acc & (mst_resp_i.b.id != AxiId)) |
                          (w_r_acc & (mst_resp_i.r.id != AxiId));
    assign w_err_set[3] = w_r_acc & ~w_rd_empty & ~mst_resp_i.r.last;

    assign w_unused_user = ^{mst_resp_i.b.user, mst_resp_i.r.user};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_err    <= '0;
        end else begin
            if (w_aw_hs && !w_b_fwd_hs)      r_wr_cnt <= r_wr_cnt + WCntW'(1);
            else if (!w_aw_hs && w_b_fwd_hs) r_wr_cnt <= r_wr_cnt - WCntW'(1);
            if (w_ar_hs && !w_r_fwd_hs)      r_rd_cnt <= r_rd_cnt + RCntW'(1);
            else if (!w_ar_hs && w_r_fwd_hs) r_rd_cnt <= r_rd_cnt - RCntW'(1);
            r_err <= (err_clr_i ? 4'b0000 : r_err) | w_err_set;
        end
    end

    always_comb begin
        mst_req_o = '0;
        mst_req_o.aw.id     = AxiId;
        mst_req_o.aw.addr   = AxiAddrWidth'(slv_req_i.aw.addr);
        mst_req_o.aw.prot   = slv_req_i.aw.prot;
        mst_req_o.aw.size   = Size;
        mst_req_o.aw.burst  = 2'b01;
        mst_req_o.aw.cache  = AxiCache;
        mst_req_o.aw.user   = {AxiUserWidth{1'b0}};
        mst_req_o.aw_valid  = slv_req_i.aw_valid & ~w_wr_full;
        mst_req_o.w.data    = slv_req_i.w.data;
        mst_req_o.w.strb    = slv_req_i.w.strb;
        mst_req_o.w.last    = 1'b1;
        mst_req_o.w_valid   = slv_req_i.w_valid;
        mst_req_o.b_ready   = w_b_ready;
        mst_req_o.ar.id     = AxiId;
        mst_req_o.ar.addr   = AxiAddrWidth'(slv_req_i.ar.addr);
        mst_req_o.ar.prot   = slv_req_i.ar.prot;
        mst_req_o.ar.size   = Size;
        mst_req_o.ar.burst  = 2'b01;
        mst_req_o.ar.cache  = AxiCache;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ~w_rd_full;
        mst_req_o.r_ready   = w_r_ready;
    end

    always_comb begin
        slv_resp_o = '0;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~w_wr_full;
        slv_resp_o.w_ready  = mst_resp_i.w_ready;
        slv_resp_o.b.resp   = mst_resp_i.b.resp;
        slv_resp_o.b_valid  = mst_resp_i.b_valid & ~w_wr_empty;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~w_rd_full;
        slv_resp_o.r.data   = mst_resp_i.r.data;
        slv_resp_o.r.resp   = mst_resp_i.r.resp;
        slv_resp_o.r_valid  = mst_resp_i.r_valid & w_r_fwd;
    end

    assign busy_o = ~w_wr_empty | ~w_rd_empty;
    assign err_o  = r_err;
endmodule

// File: tb/tb_axi_lite_to_axi_tracked.sv
// Bench for axi_lite_to_axi_tracked: directed scenarios plus a randomized run
// checked against an outstanding-count / error-flag reference model.
module tb_axi_lite_to_axi_tracked;
    import axi_lite_to_axi_tracked_pkg::*;

    localparam int MAXW = 4;
    localparam int MAXR = 4;
    localparam logic [3:0] ID = 4'd0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    lite_req_t  slv_req;
    lite_resp_t slv_resp;
    full_req_t  mst_req;
    full_resp_t mst_resp;
    logic       err_clr;
    logic       busy;
    logic [3:0] err;

    int checks = 0;
    int failures = 0;

    int m_wr, m_rd;
    logic [3:0] m_err;

    always #5 clk = ~clk;

    axi_lite_to_axi_tracked #(
        .AxiAddrWidth(32), .AxiDataWidth(32), .AxiIdWidth(4), .AxiUserWidth(1),
        .AxiId(ID), .AxiCache(4'b0011), .MaxWriteTxns(MAXW), .MaxReadTxns(MAXR)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req), .slv_resp_o(slv_resp),
        .mst_req_o(mst_req), .mst_resp_i(mst_resp),
        .err_clr_i(err_clr), .busy_o(busy), .err_o(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        slv_req = '0;
        mst_resp = '0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (err !== 4'b0) begin failures++; $display("FAIL reset_err got=%b want=0000", err); end
        slv_req.aw_valid = 1'b1;
        slv_req.ar_valid = 1'b1;
        #1;
        checks++; if (mst_req.aw_valid !== 1'b1) begin failures++; $display("FAIL reset_aw_pass got=%b want=1", mst_req.aw_valid); end
        checks++; if (mst_req.ar_valid !== 1'b1) begin failures++; $display("FAIL reset_ar_pass got=%b want=1", mst_req.ar_valid); end
        idle();
    endtask

    task automatic test_write_backpressure();
        logic [31:0] d;
        do_reset();
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            slv_req.aw_valid = 1'b1;
            slv_req.aw.addr = 32'h100 + 32'(4 * i);
            slv_req.aw.prot = 3'b010;
            slv_req.w_valid = 1'b1;
            slv_req.w.data = d;
            slv_req.w.strb = 4'hF;
            #1;
            checks++; if (slv_resp.aw_ready !== 1'b1) begin failures++; $display("FAIL wr_aw_ready[%0d] got=%b want=1", i, slv_resp.aw_ready); end
            checks++; if (mst_req.aw.addr !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL wr_aw_addr[%0d] got=%h want=%h", i, mst_req.aw.addr, 32'h100 + 32'(4 * i)); end
            checks++;
            if (mst_req.aw.len !== 8'd0 || mst_req.aw.id !== ID || mst_req.aw.size !== 3'd2 ||
                mst_req.aw.burst !== 2'b01 || mst_req.aw.cache !== 4'b0011 || mst_req.aw.prot !== 3'b010) begin
                failures++;
                $display("FAIL wr_aw_fields[%0d] got len=%0d id=%0d size=%0d burst=%0d cache=%h prot=%0d want 0/0/2/1/3/2",
                         i, mst_req.aw.len, mst_req.aw.id, mst_req.aw.size, mst_req.aw.burst, mst_req.aw.cache, mst_req.aw.prot);
            end
            checks++; if (mst_req.w.data !== d || mst_req.w.last !== 1'b1 || mst_req.w_valid !== 1'b1) begin failures++; $display("FAIL wr_w[%0d] got data=%h last=%b want data=%h last=1", i, mst_req.w.data, mst_req.w.last, d); end
            tick();
        end
        slv_req.w_valid = 1'b0;
        slv_req.aw.addr = 32'h110;
        #1;
        checks++; if (slv_resp.aw_ready !== 1'b0 || mst_req.aw_valid !== 1'b0) begin failures++; $display("FAIL wr_full_block got ready=%b valid=%b want 0/0", slv_resp.aw_ready, mst_req.aw_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b want=1", busy); end
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id = ID;
        slv_req.b_ready = 1'b1;
        #1;
        checks++; if (slv_resp.b_valid !== 1'b1 || slv_resp.aw_ready !== 1'b0) begin failures++; $display("FAIL wr_release got bvalid=%b awready=%b want 1/0", slv_resp.b_valid, slv_resp.aw_ready); end
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        checks++; if (slv_resp.aw_ready !== 1'b1) begin failures++; $display("FAIL wr_fifth_aw got=%b want=1", slv_resp.aw_ready); end
        tick();
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        repeat (4) tick();
        mst_resp.b_valid = 1'b0;
        checks++; if (busy !== 1'b0 || err !== 4'b0) begin failures++; $display("FAIL wr_drain got busy=%b err=%b want 0/0000", busy, err); end
        idle();
    endtask

    task automatic test_read();
        do_reset();
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr = 32'h200;
        mst_resp.ar_ready = 1'b1;
        #1;
        checks++; if (mst_req.ar_valid !== 1'b1 || mst_req.ar.addr !== 32'h200 || mst_req.ar.len !== 8'd0) begin failures++; $display("FAIL rd_ar got valid=%b addr=%h len=%0d want 1/200/0", mst_req.ar_valid, mst_req.ar.addr, mst_req.ar.len); end
        tick();
        slv_req.ar_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rd_busy got=%b want=1", busy); end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data = 32'hDEADBEEF;
        mst_resp.r.resp = 2'b00;
        mst_resp.r.last = 1'b1;
        mst_resp.r.id = ID;
        slv_req.r_ready = 1'b1;
        #1;
        checks++; if (slv_resp.r_valid !== 1'b1 || slv_resp.r.data !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got valid=%b data=%h want 1/deadbeef", slv_resp.r_valid, slv_resp.r.data); end
        tick();
        mst_resp.r_valid = 1'b0;
        checks++; if (busy !== 1'b0 || err !== 4'b0) begin failures++; $display("FAIL rd_done got busy=%b err=%b want 0/0000", busy, err); end
        idle();
    endtask

    task automatic test_spurious_b();
        do_reset();
        mst_resp.b_valid = 1'b1;
        slv_req.b_ready = 1'b0;
        #1;
        checks++; if (mst_req.b_ready !== 1'b1 || slv_resp.b_valid !== 1'b0) begin failures++; $display("FAIL spb_sink got bready=%b bvalid=%b want 1/0", mst_req.b_ready, slv_resp.b_valid); end
        tick();
        mst_resp.b_valid = 1'b0;
        checks++; if (err !== 4'b0001) begin failures++; $display("FAIL spb_err got=%b want=0001", err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 4'b0000) begin failures++; $display("FAIL spb_clr got=%b want=0000", err); end
        idle();
    endtask

    task automatic test_r_nolast();
        do_reset();
        slv_req.ar_valid = 1'b1;
        mst_resp.ar_ready = 1'b1;
        tick();
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last = 1'b0;
        mst_resp.r.data = 32'h11;
        slv_req.r_ready = 1'b1;
        #1;
        checks++; if (slv_resp.r_valid !== 1'b0 || mst_req.r_ready !== 1'b1) begin failures++; $display("FAIL rnl_swallow got rvalid=%b rready=%b want 0/1", slv_resp.r_valid, mst_req.r_ready); end
        tick();
        mst_resp.r.last = 1'b1;
        mst_resp.r.data = 32'h55;
        #1;
        checks++; if (slv_resp.r_valid !== 1'b1 || slv_resp.r.data !== 32'h55) begin failures++; $display("FAIL rnl_fwd got rvalid=%b data=%h want 1/55", slv_resp.r_valid, slv_resp.r.data); end
        tick();
        mst_resp.r_valid = 1'b0;
        checks++; if (err !== 4'b1000 || busy !== 1'b0) begin failures++; $display("FAIL rnl_err got err=%b busy=%b want 1000/0", err, busy); end
        idle();
    endtask

    task automatic test_bad_id();
        do_reset();
        slv_req.aw_valid = 1'b1;
        mst_resp.aw_ready = 1'b1;
        tick();
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id = ID + 4'd1;
        mst_resp.b.resp = 2'b10;
        slv_req.b_ready = 1'b1;
        #1;
        checks++; if (slv_resp.b_valid !== 1'b1 || slv_resp.b.resp !== 2'b10) begin failures++; $display("FAIL bid_fwd got bvalid=%b resp=%b want 1/10", slv_resp.b_valid, slv_resp.b.resp); end
        tick();
        mst_resp.b_valid = 1'b0;
        checks++; if (err !== 4'b0100 || busy !== 1'b0) begin failures++; $display("FAIL bid_err got err=%b busy=%b want 0100/0", err, busy); end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        mst_resp.aw_ready = 1'b1;
        slv_req.aw_valid = 1'b1;
        repeat (2) tick();
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id = ID;
        slv_req.b_ready = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (slv_resp.aw_ready !== 1'b1) begin failures++; $display("FAIL b2b_refill[%0d] got=%b want=1", i, slv_resp.aw_ready); end
            tick();
        end
        #1;
        checks++; if (slv_resp.aw_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b want=0", slv_resp.aw_ready); end
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b want=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || err !== 4'b0) begin failures++; $display("FAIL async_rst got busy=%b err=%b want 0/0000", busy, err); end
        tick();
        rst_n = 1'b1;
        mst_resp.b_valid = 1'b1;
        err_clr = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        err_clr = 1'b0;
        checks++; if (err !== 4'b0001) begin failures++; $display("FAIL late_b_set_wins got=%b want=0001", err); end
        idle();
    endtask

    task automatic test_random();
        bit awv, awr, arv, arr, bv, br, rv, rr, rl, clr;
        logic [3:0] bid, rid;
        logic [31:0] rdata;
        bit aw_acc, ar_acc, b_acc, r_acc, b_fwd, r_fwd;
        logic [3:0] nerr;
        do_reset();
        m_wr = 0; m_rd = 0; m_err = 4'b0;
        for (int c = 0; c < 500; c++) begin
            awv = ($urandom_range(0, 2) != 0); awr = ($urandom_range(0, 3) != 0);
            arv = ($urandom_range(0, 2) != 0); arr = ($urandom_range(0, 3) != 0);
            bv  = ($urandom_range(0, 2) == 0); br  = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 2) == 0); rr  = ($urandom_range(0, 3) != 0);
            rl  = ($urandom_range(0, 7) != 0); clr = ($urandom_range(0, 15) == 0);
            bid = ($urandom_range(0, 9) == 0) ? 4'd3 : ID;
            rid = ($urandom_range(0, 9) == 0) ? 4'd5 : ID;
            rdata = $urandom;
            slv_req.aw_valid = awv; mst_resp.aw_ready = awr;
            slv_req.ar_valid = arv; mst_resp.ar_ready = arr;
            mst_resp.b_valid = bv; mst_resp.b.id = bid; slv_req.b_ready = br;
            mst_resp.r_valid = rv; mst_resp.r.id = rid; mst_resp.r.last = rl;
            mst_resp.r.data = rdata; slv_req.r_ready = rr;
            err_clr = clr;
            #1;
            b_fwd = (m_wr > 0);
            r_fwd = (m_rd > 0) && rl;
            checks++;
            if (mst_req.aw_valid !== (awv && m_wr < MAXW) || slv_resp.aw_ready !== (awr && m_wr < MAXW) ||
                mst_req.ar_valid !== (arv && m_rd < MAXR) || slv_resp.ar_ready !== (arr && m_rd < MAXR)) begin
                failures++;
                $display("FAIL rnd_req[%0d] got awv=%b awr=%b arv=%b arr=%b with wr=%0d rd=%0d", c,
                         mst_req.aw_valid, slv_resp.aw_ready, mst_req.ar_valid, slv_resp.ar_ready, m_wr, m_rd);
            end
            checks++;
            if (slv_resp.b_valid !== (bv && b_fwd) || mst_req.b_ready !== (!b_fwd || br) ||
                slv_resp.r_valid !== (rv && r_fwd) || mst_req.r_ready !== (!r_fwd || rr)) begin
                failures++;
                $display("FAIL rnd_resp[%0d] got bvalid=%b bready=%b rvalid=%b rready=%b with wr=%0d rd=%0d last=%b", c,
                         slv_resp.b_valid, mst_req.b_ready, slv_resp.r_valid, mst_req.r_ready, m_wr, m_rd, rl);
            end
            if (rv && r_fwd) begin
                checks++; if (slv_resp.r.data !== rdata) begin failures++; $display("FAIL rnd_rdata[%0d] got=%h want=%h", c, slv_resp.r.data, rdata); end
            end
            aw_acc = awv && awr && (m_wr < MAXW);
            ar_acc = arv && arr && (m_rd < MAXR);
            b_acc  = bv && (!b_fwd || br);
            r_acc  = rv && (!r_fwd || rr);
            nerr = clr ? 4'b0 : m_err;
            if (b_acc && m_wr == 0) nerr[0] = 1'b1;
            if (r_acc && m_rd == 0) nerr[1] = 1'b1;
            if ((b_acc && bid != ID) || (r_acc && rid != ID)) nerr[2] = 1'b1;
            if (r_acc && m_rd > 0 && !rl) nerr[3] = 1'b1;
            m_err = nerr;
            m_wr = m_wr + int'(aw_acc) - int'(b_acc && b_fwd);
            m_rd = m_rd + int'(ar_acc) - int'(r_acc && r_fwd);
            tick();
            checks++;
            if (busy !== (m_wr != 0 || m_rd != 0) || err !== m_err) begin
                failures++;
                $display("FAIL rnd_state[%0d] got busy=%b err=%b want busy=%b err=%b", c, busy, err, (m_wr != 0 || m_rd != 0), m_err);
            end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_write_backpressure();
        test_read();
        test_spurious_b();
        test_r_nolast();
        test_bad_id();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
